// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 2W-by-W restoring divider.
// The error-fill constants are single bits, so any width can replicate them.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient is filled with this bit on divide-by-zero and on overflow.
    localparam logic QUOT_FILL    = 1'b1;
    // Remainder is filled with this bit on overflow.
    localparam logic REM_OVF_FILL = 1'b0;

endpackage

// File: rtl/seq_div_2w_by_w_if.sv
// Operand/result handshake bundle for seq_div_2w_by_w.
// The master is the producer/consumer; the slave is the divider.
interface seq_div_2w_by_w_if #(
    parameter int W = 1024
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_zero;
    logic           overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );
endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: retires one quotient bit.
// Chain k copies to build a radix-2^k iteration.
module div_restore_step #(
    parameter int W = 1024
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] q,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] q_nxt
);
    logic [W:0] t;
    logic [W:0] diff;
    logic       ge;

    // NOTE: t needs W+1 bits; rem < divisor keeps the kept result within W bits.
    assign t       = {rem, q[W-1]};
    assign ge      = (t >= {1'b0, divisor});
    assign diff    = t - {1'b0, divisor};
    assign rem_nxt = ge ? diff[W-1:0] : t[W-1:0];
    assign q_nxt   = {q[W-2:0], ge};
endmodule

// File: rtl/seq_div_2w_by_w.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per clock, valid/ready on input and output, one division in flight.
module seq_div_2w_by_w
    import div_pkg::*;
#(
    parameter int W  = 1024,
    parameter int CW = $clog2(W)
) (
    input logic                clk,
    input logic                rst_n,
    seq_div_2w_by_w_if.slave   bus
);
    div_state_e    state;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  q_r;
    logic [W-1:0]  div_r;
    logic [CW-1:0] counter;
    logic          div_zero_r;
    logic          overflow_r;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  q_nxt;

    div_restore_step #(.W(W)) u_step (
        .rem     (rem_r),
        .q       (q_r),
        .divisor (div_r),
        .rem_nxt (rem_nxt),
        .q_nxt   (q_nxt)
    );

    // q_r/rem_r double as the result registers; out_valid qualifies them.
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = q_r;
    assign bus.remainder = rem_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.overflow  = overflow_r;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            rem_r       <= '0;
            q_r         <= '0;
            div_r       <= '0;
            counter     <= '0;
            div_zero_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        div_r      <= bus.divisor;
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            div_zero_r  <= 1'b1;
                            overflow_r  <= 1'b0;
                            q_r         <= {W{QUOT_FILL}};
                            rem_r       <= bus.dividend[W-1:0];
                        end else if (bus.dividend[2*W-1:W] >= bus.divisor) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            div_zero_r  <= 1'b0;
                            overflow_r  <= 1'b1;
                            q_r         <= {W{QUOT_FILL}};
                            rem_r       <= {W{REM_OVF_FILL}};
                        end else begin
                            state      <= RUN;
                            div_zero_r <= 1'b0;
                            overflow_r <= 1'b0;
                            rem_r      <= bus.dividend[2*W-1:W];
                            q_r        <= bus.dividend[W-1:0];
                            counter    <= CW'(W - 1);
                        end
                    end
                end
                RUN: begin
                    rem_r <= rem_nxt;
                    q_r   <= q_nxt;
                    if (counter == '0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
